// File: rtl/fwrisc_trace_fifo.sv
// Trace capture FIFO: serialises per-cycle retire/register/memory events into records drained over valid/ready.
// Optional macro FWRISC_TRACE_FIFO_TIMESTAMP_EN adds a per-record 32-bit capture-cycle timestamp.
module fwrisc_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] instr,
    input  logic        ivalid,
    input  logic [5:0]  raddr,
    input  logic [31:0] rdata,
    input  logic        rwrite,
    input  logic [31:0] maddr,
    input  logic [31:0] mdata,
    input  logic [3:0]  mstrb,
    input  logic        mwrite,
    input  logic        mvalid,
    input  logic        clear,
    output logic        tvalid,
    input  logic        tready,
    output logic [1:0]  ttype,
    output logic [5:0]  taux,
    output logic [31:0] tdata0,
    output logic [31:0] tdata1,
    output logic [31:0] ttime,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int AW = $clog2(DEPTH);

`ifdef FWRISC_TRACE_FIFO_TIMESTAMP_EN
    typedef struct packed {
        logic [1:0]  typ;
        logic [5:0]  aux;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] ts;
    } entry_t;
`else
    typedef struct packed {
        logic [1:0]  typ;
        logic [5:0]  aux;
        logic [31:0] d0;
        logic [31:0] d1;
    } entry_t;
`endif

    entry_t        mem [DEPTH];
    entry_t        e_instr, e_reg, e_mem, head;
    logic [AW-1:0] wptr, rptr, reg_slot, mem_slot;
    logic [AW:0]   count, free, n_ext, add, sub;
    logic [1:0]    n;
    logic          fits, push, drop, pop;
    logic [16:0]   drop_sum;

    assign n        = {1'b0, ivalid} + {1'b0, rwrite} + {1'b0, mvalid};
    assign n_ext    = {{(AW-1){1'b0}}, n};
    // Same-cycle pop is deliberately not credited: a full FIFO drops even while draining.
    assign free     = (AW+1)'(DEPTH) - count;
    assign fits     = n_ext <= free;
    assign push     = fits && (n != 2'd0) && !clear;
    assign drop     = !fits && !clear;
    assign tvalid   = (count != '0);
    assign pop      = tvalid && tready;
    assign add      = push ? n_ext : '0;
    assign sub      = {{AW{1'b0}}, pop};
    assign reg_slot = wptr + AW'(ivalid);
    assign mem_slot = wptr + AW'(ivalid) + AW'(rwrite);
    assign drop_sum = {1'b0, drop_count} + {15'd0, n};

`ifdef FWRISC_TRACE_FIFO_TIMESTAMP_EN
    logic [31:0] tstamp;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tstamp <= '0;
        else        tstamp <= tstamp + 32'd1;
    end
`endif

    // NOTE: every field gets a default before the conditional overrides, so no latch is inferred.
    always_comb begin
        e_instr     = '0;
        e_instr.typ = 2'b01;
        e_instr.d0  = addr;
        e_instr.d1  = instr;
        e_reg       = '0;
        e_reg.typ   = 2'b10;
        e_reg.aux   = raddr;
        e_reg.d0    = rdata;
        e_mem       = '0;
        e_mem.typ   = 2'b11;
        e_mem.aux   = {mwrite, 1'b0, mstrb};
        e_mem.d0    = maddr;
        e_mem.d1    = mdata;
`ifdef FWRISC_TRACE_FIFO_TIMESTAMP_EN
        e_instr.ts  = tstamp;
        e_reg.ts    = tstamp;
        e_mem.ts    = tstamp;
`endif
    end

    // NOTE: entry storage has no reset; validity is tracked solely by count, which keeps the array plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            if (ivalid) mem[wptr]     <= e_instr;
            if (rwrite) mem[reg_slot] <= e_reg;
            if (mvalid) mem[mem_slot] <= e_mem;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(n);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + add - sub;
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    assign head   = mem[rptr];
    assign ttype  = head.typ;
    assign taux   = head.aux;
    assign tdata0 = head.d0;
    assign tdata1 = head.d1;
`ifdef FWRISC_TRACE_FIFO_TIMESTAMP_EN
    assign ttime  = head.ts;
`else
    assign ttime  = 32'h0;
`endif

endmodule
